episode_driver: RTL and testbench

//  Transaction initiator for the q_learning core: owns agent state, picks actions, steps a

---
 rtl/episode_driver_pkg.sv | 50 +++++
 rtl/episode_driver_grid_env.sv | 81 ++++++++
 rtl/episode_driver.sv | 175 +++++++++++++++++
 tb/tb_episode_driver.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/episode_driver_pkg.sv
// ---------------------------------------------------------------------------
// Module : episode_driver_pkg
// Shared constants, action encodings, FSM states and LFSR step for the episode driver.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package episode_driver_pkg;

    localparam int c_DATA_WIDTH     = 32;
    localparam int c_STATES_WIDTH   = 4;
    localparam int c_ACTIONS_WIDTH  = 2;
    localparam int c_GRID_W         = 4;
    localparam int c_GRID_H         = 4;
    localparam int c_START_ST       = 0;
    localparam int c_GOAL_ST        = 15;
    localparam int c_NUMBER_OF_LOOP = 100;
    localparam int c_NUMBER_OF_STEP = 50;
    localparam int c_TIMEOUT        = 1023;

    // Rewards in Q16.16: +1.0, -0.5 and -0.01 (truncated toward zero)
    localparam int c_FRAC_BITS      = 16;
    localparam int c_REWARD_GOAL    = 1 <<< c_FRAC_BITS;
    localparam int c_REWARD_WALL    = -(1 <<< (c_FRAC_BITS - 1));
    localparam int c_REWARD_STEP    = -((1 <<< c_FRAC_BITS) / 100);

    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] c_LFSR_MASK = 16'hB400;

    localparam int c_ACT_UP    = 0;
    localparam int c_ACT_DOWN  = 1;
    localparam int c_ACT_LEFT  = 2;
    localparam int c_ACT_RIGHT = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_ADVANCE = 3'd3,
        S_FLUSH   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        lfsr_next = v[0] ? ((v >> 1) ^ c_LFSR_MASK) : (v >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/episode_driver_grid_env.sv
// ---------------------------------------------------------------------------
// Module : episode_driver_grid_env
// Combinational grid-world step: (state, action) -> (next state, reward).
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module episode_driver_grid_env
    import episode_driver_pkg::*;
#(
    parameter int DATA_WIDTH    = c_DATA_WIDTH,
    parameter int STATES_WIDTH  = c_STATES_WIDTH,
    parameter int ACTIONS_WIDTH = c_ACTIONS_WIDTH,
    parameter int GRID_W        = c_GRID_W,
    parameter int GRID_H        = c_GRID_H,
    parameter int GOAL_ST       = c_GOAL_ST,
    parameter int REWARD_GOAL   = c_REWARD_GOAL,
    parameter int REWARD_WALL   = c_REWARD_WALL,
    parameter int REWARD_STEP   = c_REWARD_STEP
) (
    input  logic [STATES_WIDTH-1:0]  i_st,
    input  logic [ACTIONS_WIDTH-1:0] i_at,
    output logic [STATES_WIDTH-1:0]  o_next_st,
    output logic [DATA_WIDTH-1:0]    o_rt
);

    localparam int c_COL_W = $clog2(GRID_W);
    localparam int c_ROW_W = $clog2(GRID_H);

    logic [c_ROW_W-1:0]         w_row, w_nrow;
    logic [c_COL_W-1:0]         w_col, w_ncol;
    logic                       w_wall;
    logic [STATES_WIDTH-1:0]    w_moved;

    assign w_col = i_st[c_COL_W-1:0];
    assign w_row = i_st[c_COL_W +: c_ROW_W];

    always_comb begin
        w_wall = 1'b0;
        w_nrow = w_row;
        w_ncol = w_col;
        case (i_at)
            ACTIONS_WIDTH'(c_ACT_UP): begin
                if (w_row == '0) w_wall = 1'b1;
                else             w_nrow = w_row - 1'b1;
            end
            ACTIONS_WIDTH'(c_ACT_DOWN): begin
                if (w_row == c_ROW_W'(GRID_H - 1)) w_wall = 1'b1;
                else                               w_nrow = w_row + 1'b1;
            end
            ACTIONS_WIDTH'(c_ACT_LEFT): begin
                if (w_col == '0) w_wall = 1'b1;
                else             w_ncol = w_col - 1'b1;
            end
            ACTIONS_WIDTH'(c_ACT_RIGHT): begin
                if (w_col == c_COL_W'(GRID_W - 1)) w_wall = 1'b1;
                else                               w_ncol = w_col + 1'b1;
            end
            default: w_wall = 1'b0;
        endcase
    end

    assign w_moved = STATES_WIDTH'({w_nrow, w_ncol});

    // Border hit outranks the goal test: a blocked move never scores the goal.
    always_comb begin
        if (w_wall) begin
            o_next_st = i_st;
            o_rt      = DATA_WIDTH'(REWARD_WALL);
        end else if (w_moved == STATES_WIDTH'(GOAL_ST)) begin
            o_next_st = w_moved;
            o_rt      = DATA_WIDTH'(REWARD_GOAL);
        end else begin
            o_next_st = w_moved;
            o_rt      = DATA_WIDTH'(REWARD_STEP);
        end
    end

endmodule

`default_nettype wire

// File: rtl/episode_driver.sv
// ---------------------------------------------------------------------------
// Module : episode_driver
// Q-learning transaction initiator: walks the grid with LFSR actions, one update in flight.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module episode_driver
    import episode_driver_pkg::*;
#(
    parameter int          DATA_WIDTH     = c_DATA_WIDTH,
    parameter int          STATES_WIDTH   = c_STATES_WIDTH,
    parameter int          ACTIONS_WIDTH  = c_ACTIONS_WIDTH,
    parameter int          GRID_W         = c_GRID_W,
    parameter int          GRID_H         = c_GRID_H,
    parameter int          START_ST       = c_START_ST,
    parameter int          GOAL_ST        = c_GOAL_ST,
    parameter int          NUMBER_OF_LOOP = c_NUMBER_OF_LOOP,
    parameter int          NUMBER_OF_STEP = c_NUMBER_OF_STEP,
    parameter int          REWARD_GOAL    = c_REWARD_GOAL,
    parameter int          REWARD_WALL    = c_REWARD_WALL,
    parameter int          REWARD_STEP    = c_REWARD_STEP,
    parameter logic [15:0] LFSR_SEED      = c_LFSR_SEED,
    parameter int          TIMEOUT        = c_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic                     i_q_done,
    output logic                     o_valid,
    output logic [STATES_WIDTH-1:0]  o_st,
    output logic [STATES_WIDTH-1:0]  o_next_st,
    output logic [ACTIONS_WIDTH-1:0] o_at,
    output logic [DATA_WIDTH-1:0]    o_rt,
    output logic                     o_write_file_en,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_error
);

    localparam int c_STEP_W = $clog2(NUMBER_OF_STEP + 1);
    localparam int c_EP_W   = $clog2(NUMBER_OF_LOOP + 1);
    localparam int c_WAIT_W = $clog2(TIMEOUT + 1);

    state_t                     r_state, w_state_nxt;
    logic [c_STEP_W-1:0]        r_step;
    logic [c_EP_W-1:0]          r_episode;
    logic [c_WAIT_W-1:0]        r_wait_cnt;
    logic [15:0]                r_lfsr;
    logic                       r_q_pend;
    logic                       r_error;
    logic [STATES_WIDTH-1:0]    r_st, r_next_st;
    logic [ACTIONS_WIDTH-1:0]   r_at;
    logic [DATA_WIDTH-1:0]      r_rt;

    logic                       w_run_start, w_ep_end, w_last, w_done_seen, w_timeout;
    logic [15:0]                w_lfsr_adv;
    logic [STATES_WIDTH-1:0]    w_st_adv, w_env_st, w_env_next;
    logic [ACTIONS_WIDTH-1:0]   w_env_at;
    logic [DATA_WIDTH-1:0]      w_env_rt;

    assign w_run_start = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start;
    assign w_ep_end    = (r_step == c_STEP_W'(NUMBER_OF_STEP - 1));
    assign w_last      = w_ep_end && (r_episode == c_EP_W'(NUMBER_OF_LOOP - 1));
    assign w_done_seen = i_q_done || r_q_pend;
    assign w_timeout   = !w_done_seen && (r_wait_cnt == c_WAIT_W'(TIMEOUT - 1));
    assign w_lfsr_adv  = lfsr_next(r_lfsr);
    assign w_st_adv    = (r_next_st == STATES_WIDTH'(GOAL_ST)) ? STATES_WIDTH'(START_ST) : r_next_st;

    // The environment is evaluated on the state/action the next ISSUE will present,
    // so the transaction fields can be registered on entry to ISSUE.
    assign w_env_st = (r_state == S_ADVANCE) ? w_st_adv : STATES_WIDTH'(START_ST);
    assign w_env_at = (r_state == S_ADVANCE) ? w_lfsr_adv[ACTIONS_WIDTH-1:0]
                                             : LFSR_SEED[ACTIONS_WIDTH-1:0];

    episode_driver_grid_env #(
        .DATA_WIDTH    (DATA_WIDTH),
        .STATES_WIDTH  (STATES_WIDTH),
        .ACTIONS_WIDTH (ACTIONS_WIDTH),
        .GRID_W        (GRID_W),
        .GRID_H        (GRID_H),
        .GOAL_ST       (GOAL_ST),
        .REWARD_GOAL   (REWARD_GOAL),
        .REWARD_WALL   (REWARD_WALL),
        .REWARD_STEP   (REWARD_STEP)
    ) u_env (
        .i_st      (w_env_st),
        .i_at      (w_env_at),
        .o_next_st (w_env_next),
        .o_rt      (w_env_rt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_state_nxt = S_ISSUE;
            S_ISSUE:   w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_done_seen)    w_state_nxt = S_ADVANCE;
                else if (w_timeout) w_state_nxt = S_DONE;
            end
            S_ADVANCE: w_state_nxt = w_last ? S_FLUSH : S_ISSUE;
            S_FLUSH:   w_state_nxt = S_DONE;
            S_DONE:    if (i_start) w_state_nxt = S_ISSUE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_step     <= '0;
            r_episode  <= '0;
            r_wait_cnt <= '0;
            r_lfsr     <= LFSR_SEED;
            r_q_pend   <= 1'b0;
            r_error    <= 1'b0;
            r_st       <= '0;
            r_next_st  <= '0;
            r_at       <= '0;
            r_rt       <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_run_start) begin
                r_step    <= '0;
                r_episode <= '0;
                r_lfsr    <= LFSR_SEED;
                r_error   <= 1'b0;
            end

            if (r_state == S_ISSUE) begin
                r_wait_cnt <= '0;
                r_q_pend   <= i_q_done;
            end

            if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
                r_q_pend   <= 1'b0;
                if (w_timeout) r_error <= 1'b1;
            end

            if (r_state == S_ADVANCE) begin
                r_lfsr <= w_lfsr_adv;
                if (w_ep_end) begin
                    r_step    <= '0;
                    r_episode <= r_episode + 1'b1;
                end else begin
                    r_step <= r_step + 1'b1;
                end
            end

            if (w_state_nxt == S_ISSUE) begin
                r_st      <= w_env_st;
                r_next_st <= w_env_next;
                r_at      <= w_env_at;
                r_rt      <= w_env_rt;
            end
        end
    end

    assign o_valid         = (r_state == S_ISSUE);
    assign o_write_file_en = (r_state == S_FLUSH);
    assign o_busy          = (r_state == S_ISSUE) || (r_state == S_WAIT) ||
                             (r_state == S_ADVANCE) || (r_state == S_FLUSH);
    assign o_done          = (r_state == S_DONE);
    assign o_error         = r_error;
    assign o_st            = r_st;
    assign o_next_st       = r_next_st;
    assign o_at            = r_at;
    assign o_rt            = r_rt;

endmodule

`default_nettype wire

// File: tb/tb_episode_driver.sv
// ---------------------------------------------------------------------------
// Module : tb_episode_driver
// Self-checking bench for episode_driver with a mocked q_learning core and a scoreboard.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_episode_driver;

    localparam int c_R_GOAL = 65536;
    localparam int c_R_WALL = -32768;
    localparam int c_R_STEP = -655;

    typedef struct {
        int st;
        int nst;
        int at;
        int rt;
    } tx_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // DUT A: small run (2 episodes x 3 steps), goal 15
    logic        a_start, a_q_done;
    logic        a_valid, a_wfe, a_busy, a_done, a_error;
    logic [3:0]  a_st, a_nst;
    logic [1:0]  a_at;
    logic [31:0] a_rt;

    // DUT B: 4 x 20 steps, goal placed at state 1 so restarts occur often
    logic        b_start, b_q_done;
    logic        b_valid, b_wfe, b_busy, b_done, b_error;
    logic [3:0]  b_st, b_nst;
    logic [1:0]  b_at;
    logic [31:0] b_rt;

    logic [3:0]  e_st, e_nst;
    logic [1:0]  e_at;
    logic [31:0] e_rt;

    episode_driver #(.NUMBER_OF_LOOP(2), .NUMBER_OF_STEP(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_q_done(a_q_done),
        .o_valid(a_valid), .o_st(a_st), .o_next_st(a_nst), .o_at(a_at), .o_rt(a_rt),
        .o_write_file_en(a_wfe), .o_busy(a_busy), .o_done(a_done), .o_error(a_error)
    );

    episode_driver #(.NUMBER_OF_LOOP(4), .NUMBER_OF_STEP(20), .GOAL_ST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_q_done(b_q_done),
        .o_valid(b_valid), .o_st(b_st), .o_next_st(b_nst), .o_at(b_at), .o_rt(b_rt),
        .o_write_file_en(b_wfe), .o_busy(b_busy), .o_done(b_done), .o_error(b_error)
    );

    episode_driver_grid_env u_env_chk (
        .i_st(e_st), .i_at(e_at), .o_next_st(e_nst), .o_rt(e_rt)
    );

    // Mock cores: raise i_q_done for one cycle, LAT cycles after each o_valid.
    bit a_mock_en = 0, b_mock_en = 0;
    int a_lat = 5, b_lat = 3;
    int a_cd = 0, b_cd = 0;

    always @(negedge clk) begin
        a_q_done = 1'b0;
        if (a_mock_en) begin
            if (a_cd > 0) begin
                a_cd = a_cd - 1;
                if (a_cd == 0) a_q_done = 1'b1;
            end
            if (a_valid) begin
                if (a_lat == 0) a_q_done = 1'b1;
                else            a_cd = a_lat;
            end
        end
    end

    always @(negedge clk) begin
        b_q_done = 1'b0;
        if (b_mock_en) begin
            if (b_cd > 0) begin
                b_cd = b_cd - 1;
                if (b_cd == 0) b_q_done = 1'b1;
            end
            if (b_valid) b_cd = b_lat;
        end
    end

    function automatic void env_ref(input int st, input int at, input int goal,
                                    output int nst, output int rt);
        int row, col, nr, nc;
        bit wall;
        row = st / 4; col = st % 4; nr = row; nc = col; wall = 0;
        case (at)
            0: if (row == 0) wall = 1; else nr = row - 1;
            1: if (row == 3) wall = 1; else nr = row + 1;
            2: if (col == 0) wall = 1; else nc = col - 1;
            default: if (col == 3) wall = 1; else nc = col + 1;
        endcase
        if (wall) begin
            nst = st; rt = c_R_WALL;
        end else begin
            nst = nr * 4 + nc;
            rt  = (nst == goal) ? c_R_GOAL : c_R_STEP;
        end
    endfunction

    function automatic logic [15:0] lfsr_ref(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic pulse_a();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if ({a_valid, a_st, a_nst, a_at, a_rt, a_wfe, a_busy, a_done, a_error} !== 48'd0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b st=%0d nst=%0d at=%0d rt=%0h wfe=%b busy=%b done=%b err=%b, required all 0",
                     a_valid, a_st, a_nst, a_at, a_rt, a_wfe, a_busy, a_done, a_error);
        end
        tests++;
        if ({b_valid, b_busy, b_done, b_error, b_wfe} !== 5'd0) begin
            fails++;
            $display("FAIL reset_outputs_b: got %b, required 00000", {b_valid, b_busy, b_done, b_error, b_wfe});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        bit seen = 0;
        int nw = 0, nb = 0;
        a_lat = 5; a_cd = 0; a_mock_en = 1;
        pulse_a();
        for (int k = 0; k < 20 && !seen; k++) begin
            if (a_valid) seen = 1;
            else         @(negedge clk);
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL midrst_issue: got no o_valid, required one"); end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (a_busy !== 1'b1) begin fails++; $display("FAIL midrst_busy: got %b required 1", a_busy); end
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if ({a_valid, a_st, a_nst, a_at, a_rt, a_wfe, a_busy, a_done, a_error} !== 48'd0) begin
            fails++;
            $display("FAIL midrst_outputs: got busy=%b done=%b st=%0d rt=%0h, required all 0",
                     a_busy, a_done, a_st, a_rt);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_wfe) nw++;
            if (a_busy || a_valid) nb++;
        end
        tests++;
        if (nw != 0) begin fails++; $display("FAIL midrst_wfe: got %0d pulses required 0", nw); end
        tests++;
        if (nb != 0) begin fails++; $display("FAIL midrst_idle: got %0d busy cycles required 0", nb); end
        a_mock_en = 0;
    endtask

    task automatic test_run(input int lat);
        int nv = 0, nw = 0, last_v = -1, w_k = -1, gap_bad = 0, exp_fl;
        bit done = 0;
        a_lat = lat; a_cd = 0; a_mock_en = 1;
        pulse_a();
        for (int k = 0; k < 400 && !done; k++) begin
            if (a_valid) begin
                if (nv == 0) begin
                    tests++;
                    if (a_error !== 1'b0 || a_done !== 1'b0) begin
                        fails++;
                        $display("FAIL run_clear lat=%0d: got err=%b done=%b required 0 0", lat, a_error, a_done);
                    end
                end
                if (nv > 0 && lat <= 1 && (k - last_v) != 3) gap_bad++;
                nv++;
                last_v = k;
            end
            if (a_wfe) begin nw++; w_k = k; end
            if (a_done) done = 1;
            else        @(negedge clk);
        end
        exp_fl = (lat == 0) ? 3 : lat + 2;
        tests++;
        if (!done) begin fails++; $display("FAIL run_done lat=%0d: got o_done=0 required 1", lat); end
        tests++;
        if (nv != 6) begin fails++; $display("FAIL run_strobes lat=%0d: got %0d required 6", lat, nv); end
        tests++;
        if (nw != 1) begin fails++; $display("FAIL run_wfe lat=%0d: got %0d required 1", lat, nw); end
        tests++;
        if (w_k - last_v != exp_fl) begin
            fails++;
            $display("FAIL run_wfe_time lat=%0d: got %0d required %0d", lat, w_k - last_v, exp_fl);
        end
        tests++;
        if (a_busy !== 1'b0 || a_error !== 1'b0) begin
            fails++;
            $display("FAIL run_end_flags lat=%0d: got busy=%b err=%b required 0 0", lat, a_busy, a_error);
        end
        if (lat <= 1) begin
            tests++;
            if (gap_bad != 0) begin fails++; $display("FAIL back_to_back_gap: got %0d bad gaps required 0", gap_bad); end
        end
        a_mock_en = 0;
    endtask

    task automatic test_timeout();
        int k0 = -1, kd = -1, nw = 0, nv = 0;
        a_mock_en = 0;
        pulse_a();
        for (int k = 0; k < 1200 && kd < 0; k++) begin
            if (a_valid) begin nv++; if (k0 < 0) k0 = k; end
            if (a_wfe) nw++;
            if (a_done) kd = k;
            else        @(negedge clk);
        end
        tests++;
        if (kd < 0 || kd - k0 != 1024) begin
            fails++;
            $display("FAIL timeout_time: got done at %0d cycles after ISSUE, required 1024", kd - k0);
        end
        tests++;
        if (a_error !== 1'b1) begin fails++; $display("FAIL timeout_error: got %b required 1", a_error); end
        tests++;
        if (nw != 0 || nv != 1) begin
            fails++;
            $display("FAIL timeout_strobes: got wfe=%0d valid=%0d required 0 1", nw, nv);
        end
    endtask

    task automatic test_grid_env();
        int nst, rt;
        int bad = 0;
        for (int s = 0; s < 16; s++) begin
            for (int a = 0; a < 4; a++) begin
                e_st = 4'(s); e_at = 2'(a);
                #1;
                env_ref(s, a, 15, nst, rt);
                tests++;
                if (e_nst !== 4'(nst) || e_rt !== 32'(rt)) begin
                    fails++; bad++;
                    if (bad < 8)
                        $display("FAIL grid_env st=%0d at=%0d: got nst=%0d rt=%0d required nst=%0d rt=%0d",
                                 s, a, e_nst, $signed(e_rt), nst, rt);
                end
            end
        end
        e_st = 4'd0; e_at = 2'd0; #1;
        tests++;
        if (e_nst !== 4'd0 || e_rt !== 32'hFFFF8000) begin
            fails++; $display("FAIL grid_wall: got nst=%0d rt=%0h required 0 ffff8000", e_nst, e_rt);
        end
        e_st = 4'd14; e_at = 2'd3; #1;
        tests++;
        if (e_nst !== 4'd15 || e_rt !== 32'h00010000) begin
            fails++; $display("FAIL grid_goal: got nst=%0d rt=%0h required 15 10000", e_nst, e_rt);
        end
        e_st = 4'd5; e_at = 2'd1; #1;
        tests++;
        if (e_nst !== 4'd9 || e_rt !== 32'hFFFFFD71) begin
            fails++; $display("FAIL grid_step: got nst=%0d rt=%0h required 9 fffffd71", e_nst, e_rt);
        end
    endtask

    task automatic test_scoreboard();
        tx_t q[$];
        tx_t ex, t;
        logic [15:0] l = 16'hACE1;
        int st = 0, nv = 0, nw = 0, n_goal = 0, v2_k = -1;
        bit prev_goal = 0, done = 0;
        for (int i = 0; i < 80; i++) begin
            t.st = st; t.at = int'(l[1:0]);
            env_ref(t.st, t.at, 1, t.nst, t.rt);
            q.push_back(t);
            st = (t.nst == 1) ? 0 : t.nst;
            l = lfsr_ref(l);
        end
        b_lat = 3; b_cd = 0; b_mock_en = 1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            b_start = (v2_k >= 0 && k == v2_k + 1);
            if (b_valid) begin
                nv++;
                if (nv == 2) v2_k = k;
                if (prev_goal) begin
                    tests++;
                    if (b_st !== 4'd0) begin
                        fails++; $display("FAIL goal_restart tx=%0d: got o_st=%0d required 0", nv, b_st);
                    end
                    n_goal++;
                end
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL sb_extra tx=%0d: got unexpected o_valid, required none", nv);
                end else begin
                    ex = q.pop_front();
                    if (b_st !== 4'(ex.st) || b_nst !== 4'(ex.nst) || b_at !== 2'(ex.at) || b_rt !== 32'(ex.rt)) begin
                        fails++;
                        $display("FAIL sb_tx %0d: got st=%0d nst=%0d at=%0d rt=%0d required st=%0d nst=%0d at=%0d rt=%0d",
                                 nv, b_st, b_nst, b_at, $signed(b_rt), ex.st, ex.nst, ex.at, ex.rt);
                    end
                    prev_goal = (ex.nst == 1);
                end
            end
            if (b_wfe) nw++;
            if (b_done) done = 1;
            else        @(negedge clk);
        end
        b_start = 1'b0;
        tests++;
        if (nv != 80 || q.size() != 0) begin
            fails++; $display("FAIL sb_count: got %0d strobes (%0d unmatched) required 80", nv, q.size());
        end
        tests++;
        if (nw != 1 || !done) begin
            fails++; $display("FAIL sb_end: got wfe=%0d done=%b required 1 1", nw, done);
        end
        tests++;
        if (n_goal == 0) begin fails++; $display("FAIL goal_seen: got 0 goal restarts required >0"); end
        b_mock_en = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_start = 1'b0; b_start = 1'b0;
        e_st = '0; e_at = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_reset_mid_run();
        test_run(5);
        test_run(0);
        test_run(1);
        test_timeout();
        test_run(5);
        test_grid_env();
        @(negedge clk);
        test_scoreboard();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
